// File: rtl/mu0_pkg.sv
// Shared MU0 definitions: opcodes, ALU functions, datapath select codes and the
// control-unit decode function used by mu0_control.
package mu0_pkg;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_STO = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_JMP = 4'd4;
  localparam logic [3:0] OP_JGE = 4'd5;
  localparam logic [3:0] OP_JNE = 4'd6;
  localparam logic [3:0] OP_STP = 4'd7;

  localparam logic [2:0] ALU_ZERO  = 3'd0;
  localparam logic [2:0] ALU_ADD   = 3'd1;
  localparam logic [2:0] ALU_SUB   = 3'd2;
  localparam logic [2:0] ALU_PASSB = 3'd3;
  localparam logic [2:0] ALU_INCB  = 3'd4;

  localparam logic [1:0] BSEL_PC  = 2'd0;
  localparam logic [1:0] BSEL_MEM = 2'd1;
  localparam logic [1:0] BSEL_IR  = 2'd2;

  typedef struct packed {
    logic [2:0] alufs;
    logic       a_sel;
    logic [1:0] b_sel;
    logic       acc_ce;
    logic       pc_ce;
    logic       ir_ce;
    logic       acc_oe;
    logic       mem_rq;
    logic       rnw;
    logic       halted;
  } ctrl_t;

  typedef struct packed {
    ctrl_t  ctrl;
    state_t nxt;
    logic   set_illegal;
    logic   retire;
  } decode_t;

  // Pure decode of the current state and inputs into datapath controls plus
  // the next-state / side-effect requests for the sequencer.
  function automatic decode_t mu0_decode(input state_t     state,
                                         input logic [3:0] opcode,
                                         input logic       acc_z,
                                         input logic       acc_n,
                                         input logic       mem_rdy,
                                         input logic       halt_on_illegal);
    decode_t d;
    logic    take;
    // NOTE: everything gets a default first so no path through the case can
    // leave a bit unassigned and infer a latch.
    d     = '0;
    d.nxt = state;
    take  = 1'b0;
    case (state)
      ST_RST: begin
        d.ctrl.alufs = ALU_ZERO;
        d.ctrl.b_sel = BSEL_PC;
        d.ctrl.pc_ce = 1'b1;
        d.nxt        = ST_FETCH;
      end
      ST_FETCH: begin
        d.ctrl.a_sel  = 1'b0;
        d.ctrl.b_sel  = BSEL_PC;
        d.ctrl.alufs  = ALU_INCB;
        d.ctrl.mem_rq = 1'b1;
        d.ctrl.rnw    = 1'b1;
        d.ctrl.pc_ce  = mem_rdy;
        d.ctrl.ir_ce  = mem_rdy;
        if (mem_rdy) d.nxt = ST_EXEC;
      end
      ST_EXEC: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            d.ctrl.a_sel  = 1'b1;
            d.ctrl.mem_rq = 1'b1;
            d.ctrl.rnw    = 1'b1;
            d.ctrl.b_sel  = BSEL_MEM;
            d.ctrl.alufs  = (opcode == OP_LDA) ? ALU_PASSB :
                            (opcode == OP_ADD) ? ALU_ADD : ALU_SUB;
            d.ctrl.acc_ce = mem_rdy;
            if (mem_rdy) begin
              d.nxt    = ST_FETCH;
              d.retire = 1'b1;
            end
          end
          OP_STO: begin
            d.ctrl.a_sel  = 1'b1;
            d.ctrl.mem_rq = 1'b1;
            d.ctrl.rnw    = 1'b0;
            d.ctrl.acc_oe = 1'b1;
            d.ctrl.alufs  = ALU_ZERO;
            if (mem_rdy) begin
              d.nxt    = ST_FETCH;
              d.retire = 1'b1;
            end
          end
          OP_JMP, OP_JGE, OP_JNE: begin
            // Flags are those of the accumulator in this same cycle.
            take = (opcode == OP_JMP) ||
                   (opcode == OP_JGE && !acc_n) ||
                   (opcode == OP_JNE && !acc_z);
            if (take) begin
              d.ctrl.b_sel = BSEL_IR;
              d.ctrl.alufs = ALU_PASSB;
              d.ctrl.pc_ce = 1'b1;
            end
            d.nxt    = ST_FETCH;
            d.retire = 1'b1;
          end
          OP_STP: d.nxt = ST_HALT;
          default: begin
            if (halt_on_illegal) begin
              d.set_illegal = 1'b1;
              d.nxt         = ST_HALT;
            end else begin
              d.nxt    = ST_FETCH;
              d.retire = 1'b1;
            end
          end
        endcase
      end
      default: begin
        d.ctrl.halted = 1'b1;
        d.nxt         = ST_HALT;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mu0_control.sv
// MU0 control unit: sequences reset/fetch/execute/halt, decodes opcodes into
// datapath controls, stalls on mem_rdy and counts retired instructions.
module mu0_control
  import mu0_pkg::*;
#(
  parameter int CNT_W           = 16,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       opcode,
  input  logic             acc_z,
  input  logic             acc_n,
  input  logic             mem_rdy,
  output logic [2:0]       alufs,
  output logic             a_sel,
  output logic [1:0]       b_sel,
  output logic             acc_ce,
  output logic             pc_ce,
  output logic             ir_ce,
  output logic             acc_oe,
  output logic             mem_rq,
  output logic             rnw,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t             state;
  decode_t            dec;
  logic               illegal_q;
  logic [CNT_W-1:0]   retired_q;

  always_comb begin
    dec = mu0_decode(state, opcode, acc_z, acc_n, mem_rdy, HALT_ON_ILLEGAL);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_RST;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state <= dec.nxt;
      if (dec.set_illegal) illegal_q <= 1'b1;
      if (dec.retire)      retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Controls are combinational so a reset drops mem_rq in the same cycle.
  assign alufs   = dec.ctrl.alufs;
  assign a_sel   = dec.ctrl.a_sel;
  assign b_sel   = dec.ctrl.b_sel;
  assign acc_ce  = dec.ctrl.acc_ce;
  assign pc_ce   = dec.ctrl.pc_ce;
  assign ir_ce   = dec.ctrl.ir_ce;
  assign acc_oe  = dec.ctrl.acc_oe;
  assign mem_rq  = dec.ctrl.mem_rq;
  assign rnw     = dec.ctrl.rnw;
  assign halted  = dec.ctrl.halted;
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mu0_control.sv
// Self-checking bench for mu0_control: directed program steps plus random
// stimulus, checked every cycle against an instruction-level reference model.
module tb_mu0_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] opcode = 4'd0;
  logic       acc_z = 1'b0, acc_n = 1'b0, mem_rdy = 1'b0;

  logic [2:0]  a_alufs, b_alufs;
  logic        a_a_sel, b_a_sel;
  logic [1:0]  a_b_sel, b_b_sel;
  logic        a_acc_ce, a_pc_ce, a_ir_ce, a_acc_oe, a_mem_rq, a_rnw, a_halted, a_illegal;
  logic        b_acc_ce, b_pc_ce, b_ir_ce, b_acc_oe, b_mem_rq, b_rnw, b_halted, b_illegal;
  logic [15:0] a_retired;
  logic [3:0]  b_retired;

  mu0_control #(.CNT_W(16), .HALT_ON_ILLEGAL(1'b1)) dut_a (
    .clk(clk), .reset(reset), .opcode(opcode), .acc_z(acc_z), .acc_n(acc_n),
    .mem_rdy(mem_rdy), .alufs(a_alufs), .a_sel(a_a_sel), .b_sel(a_b_sel),
    .acc_ce(a_acc_ce), .pc_ce(a_pc_ce), .ir_ce(a_ir_ce), .acc_oe(a_acc_oe),
    .mem_rq(a_mem_rq), .rnw(a_rnw), .halted(a_halted), .illegal(a_illegal),
    .retired(a_retired));

  // Narrow counter and no-op illegals, so wrap and the other illegal policy are reachable.
  mu0_control #(.CNT_W(4), .HALT_ON_ILLEGAL(1'b0)) dut_b (
    .clk(clk), .reset(reset), .opcode(opcode), .acc_z(acc_z), .acc_n(acc_n),
    .mem_rdy(mem_rdy), .alufs(b_alufs), .a_sel(b_a_sel), .b_sel(b_b_sel),
    .acc_ce(b_acc_ce), .pc_ce(b_pc_ce), .ir_ce(b_ir_ce), .acc_oe(b_acc_oe),
    .mem_rq(b_mem_rq), .rnw(b_rnw), .halted(b_halted), .illegal(b_illegal),
    .retired(b_retired));

  always #5 clk = ~clk;

  wire [12:0] a_ctl = {a_alufs, a_a_sel, a_b_sel, a_acc_ce, a_pc_ce, a_ir_ce,
                       a_acc_oe, a_mem_rq, a_rnw, a_halted};
  wire [12:0] b_ctl = {b_alufs, b_a_sel, b_b_sel, b_acc_ce, b_pc_ce, b_ir_ce,
                       b_acc_oe, b_mem_rq, b_rnw, b_halted};

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 reset, 1 fetch, 2 execute, 3 halted.
  int ph_a, ph_b, ret_a, ret_b;
  bit ill_a, ill_b;
  logic [2:0] last_alufs;
  logic       last_pc_ce;
  logic [1:0] last_b_sel;
  logic [2:0] alu_seq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] expect_ctl(input int ph, input logic [3:0] op,
                                             input logic z, input logic n, input logic rdy);
    logic [2:0] alu;
    logic [1:0] bsel;
    logic asel, ace, pce, ice, aoe, rq, rw, hlt, take;
    {alu, bsel, asel, ace, pce, ice, aoe, rq, rw, hlt, take} = '0;
    if (ph == 0) pce = 1'b1;
    else if (ph == 1) begin
      alu = 3'd4; rq = 1'b1; rw = 1'b1; pce = rdy; ice = rdy;
    end else if (ph == 3) hlt = 1'b1;
    else if (op == 4'd1) begin
      asel = 1'b1; rq = 1'b1; aoe = 1'b1;
    end else if (op <= 4'd3) begin
      asel = 1'b1; rq = 1'b1; rw = 1'b1; bsel = 2'd1; ace = rdy;
      alu = (op == 4'd0) ? 3'd3 : 3'(op - 4'd1);
    end else if (op <= 4'd6) begin
      take = (op == 4'd4) || (op == 4'd5 && !n) || (op == 4'd6 && !z);
      if (take) begin
        bsel = 2'd2; alu = 3'd3; pce = 1'b1;
      end
    end
    return {alu, asel, bsel, ace, pce, ice, aoe, rq, rw, hlt};
  endfunction

  task automatic advance(input int ph, input bit ill, input int ret, input int w,
                         input bit hoi, input logic [3:0] op, input logic rdy,
                         output int ph_o, output bit ill_o, output int ret_o);
    ph_o = ph; ill_o = ill; ret_o = ret;
    case (ph)
      0: ph_o = 1;
      1: if (rdy) ph_o = 2;
      2: begin
        if (op <= 4'd3) begin
          if (rdy) begin ph_o = 1; ret_o = ret + 1; end
        end else if (op <= 4'd6 || (op >= 4'd8 && !hoi)) begin
          ph_o = 1; ret_o = ret + 1;
        end else if (op == 4'd7) ph_o = 3;
        else begin ph_o = 3; ill_o = 1'b1; end
      end
      default: ph_o = 3;
    endcase
    ret_o = ret_o % (1 << w);
  endtask

  task automatic model_reset();
    ph_a = 0; ph_b = 0; ret_a = 0; ret_b = 0; ill_a = 1'b0; ill_b = 1'b0;
  endtask

  task automatic step(input logic rst, input logic [3:0] op, input logic z,
                      input logic n, input logic rdy);
    @(negedge clk);
    reset = rst; opcode = op; acc_z = z; acc_n = n; mem_rdy = rdy;
    if (rst) model_reset();
    #1;
    check("a_ctl", 32'(a_ctl), 32'(expect_ctl(ph_a, op, z, n, rdy)));
    check("a_illegal", 32'(a_illegal), 32'(ill_a));
    check("a_retired", 32'(a_retired), 32'(ret_a));
    check("b_ctl", 32'(b_ctl), 32'(expect_ctl(ph_b, op, z, n, rdy)));
    check("b_illegal", 32'(b_illegal), 32'(ill_b));
    check("b_retired", 32'(b_retired), 32'(ret_b));
    last_alufs = a_alufs; last_pc_ce = a_pc_ce; last_b_sel = a_b_sel;
    @(posedge clk);
    if (!rst) begin
      advance(ph_a, ill_a, ret_a, 16, 1'b1, op, rdy, ph_a, ill_a, ret_a);
      advance(ph_b, ill_b, ret_b, 4, 1'b0, op, rdy, ph_b, ill_b, ret_b);
    end
  endtask

  initial begin
    logic [3:0] prog [5];
    logic [2:0] exp_seq [9];
    int r0;
    prog = '{4'd0, 4'd2, 4'd3, 4'd1, 4'd7};
    exp_seq = '{3'd4, 3'd3, 3'd4, 3'd1, 3'd4, 3'd2, 3'd4, 3'd0, 3'd4};
    model_reset();

    // Reset and release with mem_rdy high: RST then FETCH.
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check("rst_pc_ce", 32'(last_pc_ce), 1);
    check("rst_alufs", 32'(last_alufs), 0);

    // LDA, ADD, SUB, STO, STP back to back.
    for (int i = 0; i < 5; i++) begin
      step(0, prog[i], 0, 0, 1);
      alu_seq.push_back(last_alufs);
      step(0, prog[i], 0, 0, 1);
      alu_seq.push_back(last_alufs);
    end
    for (int i = 0; i < 9; i++) check("prog_alufs", 32'(alu_seq[i]), 32'(exp_seq[i]));
    step(0, 0, 0, 0, 1);
    check("stp_halted", 32'(a_halted), 1);
    check("stp_retired", 32'(a_retired), 4);

    // Stalls in FETCH and in ADD.
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 2, 0, 0, 0);
    step(0, 2, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 2, 0, 0, 0);
    step(0, 2, 0, 0, 1);

    // JGE not taken, JGE taken, JNE not taken.
    r0 = ret_a;
    step(0, 5, 0, 1, 1); step(0, 5, 0, 1, 1);
    check("jge_n1_pc_ce", 32'(last_pc_ce), 0);
    step(0, 5, 0, 0, 1); step(0, 5, 0, 0, 1);
    check("jge_n0_pc_ce", 32'(last_pc_ce), 1);
    check("jge_n0_b_sel", 32'(last_b_sel), 2);
    check("jge_n0_alufs", 32'(last_alufs), 3);
    step(0, 6, 1, 0, 1); step(0, 6, 1, 0, 1);
    check("jne_z1_pc_ce", 32'(last_pc_ce), 0);
    #1 check("jump_retired", 32'(a_retired), 32'(r0 + 3));

    // Illegal opcode: dut_a halts sticky-illegal, dut_b treats it as a no-op.
    r0 = ret_a;
    step(0, 4'hA, 0, 0, 1); step(0, 4'hA, 0, 0, 1);
    #1;
    check("ill_a_flag", 32'(a_illegal), 1);
    check("ill_a_halted", 32'(a_halted), 1);
    check("ill_a_retired", 32'(a_retired), 32'(r0));
    check("ill_b_flag", 32'(b_illegal), 0);

    // dut_b enters an LDA stall, then reset lands mid-cycle.
    step(0, 0, 0, 0, 1);
    @(negedge clk);
    opcode = 4'd0; mem_rdy = 1'b0;
    #1 check("stall_b_rq", 32'(b_mem_rq), 1);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("async_b_rq", 32'(b_mem_rq), 0);
    check("async_b_pc_ce", 32'(b_pc_ce), 1);
    check("async_a_illegal", 32'(a_illegal), 0);
    check("async_a_retired", 32'(a_retired), 0);
    check("async_a_halted", 32'(a_halted), 0);

    // 16 jumps wrap the 4-bit counter of dut_b to zero.
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      step(0, 4, 0, 0, 1);
      step(0, 4, 0, 0, 1);
    end
    #1;
    check("wrap_b_retired", 32'(b_retired), 0);
    check("wrap_a_retired", 32'(a_retired), 16);

    // Random instruction streams, random ready and flags, occasional reset.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0,
           4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
